// File: rtl/seg7_debug_display.sv
// rtl/seg7_debug_display.sv - snapshots core debug values and scans one 32-bit page onto an 8-digit 7-seg display
module seg7_debug_display #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_clk,
    input  logic [63:0] pc,
    input  logic [63:0] alures,
    input  logic        zero,
    input  logic        page_btn,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  page
);
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          cpu_meta, cpu_sync_q, cpu_sync_qq;
    logic          btn_meta, btn_sync, btn_level;
    logic [DW-1:0] db_cnt;
    logic [SW-1:0] presc;
    logic [2:0]    idx;
    logic [63:0]   pc_shadow, alu_shadow;
    logic          zero_shadow;
    logic          cpu_rise;
    logic [31:0]   page_word;
    logic [3:0]    nibble;
    logic [6:0]    seg_next;

    assign cpu_rise = cpu_sync_q & ~cpu_sync_qq;

    always_comb begin
        page_word = pc_shadow[31:0];
        case (page)
            2'd0: page_word = pc_shadow[31:0];
            2'd1: page_word = pc_shadow[63:32];
            2'd2: page_word = alu_shadow[31:0];
            2'd3: page_word = alu_shadow[63:32];
            default: page_word = pc_shadow[31:0];
        endcase
        nibble = page_word[{idx, 2'b00} +: 4];
    end

    always_comb begin
        seg_next = 7'h7F;
        case (nibble)
            4'h0: seg_next = 7'h40;
            4'h1: seg_next = 7'h79;
            4'h2: seg_next = 7'h24;
            4'h3: seg_next = 7'h30;
            4'h4: seg_next = 7'h19;
            4'h5: seg_next = 7'h12;
            4'h6: seg_next = 7'h02;
            4'h7: seg_next = 7'h78;
            4'h8: seg_next = 7'h00;
            4'h9: seg_next = 7'h10;
            4'hA: seg_next = 7'h08;
            4'hB: seg_next = 7'h03;
            4'hC: seg_next = 7'h46;
            4'hD: seg_next = 7'h21;
            4'hE: seg_next = 7'h06;
            4'hF: seg_next = 7'h0E;
            default: seg_next = 7'h7F;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_meta    <= 1'b0;
            cpu_sync_q  <= 1'b0;
            cpu_sync_qq <= 1'b0;
            btn_meta    <= 1'b0;
            btn_sync    <= 1'b0;
            btn_level   <= 1'b0;
            db_cnt      <= '0;
            presc       <= '0;
            idx         <= 3'd0;
            pc_shadow   <= 64'd0;
            alu_shadow  <= 64'd0;
            zero_shadow <= 1'b0;
            page        <= 2'd0;
            an          <= 8'hFF;
            seg         <= 7'h7F;
            dp          <= 1'b1;
        end else begin
            // cpu_clk is only ever data here; cpu_sync_qq exists purely for edge detection
            cpu_meta    <= cpu_clk;
            cpu_sync_q  <= cpu_meta;
            cpu_sync_qq <= cpu_sync_q;
            if (cpu_rise) begin
                pc_shadow   <= pc;
                alu_shadow  <= alures;
                zero_shadow <= zero;
            end

            btn_meta <= page_btn;
            btn_sync <= btn_meta;
            if (btn_sync == btn_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt    <= '0;
                btn_level <= btn_sync;
                if (btn_sync)
                    page <= page + 2'd1;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

            if (presc == SW'(SCAN_DIV - 1)) begin
                presc <= '0;
                idx   <= idx + 3'd1;
            end else begin
                presc <= presc + 1'b1;
            end

            // Outputs reflect the current idx, so they trail the digit counter by one clock
            an  <= ~(8'b1 << idx);
            seg <= seg_next;
            dp  <= ~((idx == 3'd0) & zero_shadow);
        end
    end
endmodule

// File: tb/tb_seg7_debug_display.sv
// tb/tb_seg7_debug_display.sv - randomized self-checking bench for seg7_debug_display
module tb_seg7_debug_display;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_clk = 1'b0;
    logic [63:0] pc = 64'd0;
    logic [63:0] alures = 64'd0;
    logic        zero = 1'b0;
    logic        page_btn = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  page;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit x_watch = 1'b0;

    logic [63:0] pc_m = 64'd0;
    logic [63:0] alu_m = 64'd0;
    logic        zero_m = 1'b0;
    int          page_m = 0;

    seg7_debug_display #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .reset(reset), .cpu_clk(cpu_clk), .pc(pc), .alures(alures),
        .zero(zero), .page_btn(page_btn), .an(an), .seg(seg), .dp(dp), .page(page)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (x_watch)
            check("no_x", 32'($isunknown({an, seg, dp, page})), 32'd0);
    end

    function automatic logic [6:0] hex_seg(input int v);
        case (v)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
            12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [31:0] model_word();
        case (page_m)
            0: return pc_m[31:0];
            1: return pc_m[63:32];
            2: return alu_m[31:0];
            default: return alu_m[63:32];
        endcase
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Display at edge k (counted from reset release) shows digit ((k-1)/SCAN_DIV) mod 8
    task automatic check_frame();
        for (int i = 0; i < 8 * SCAN_DIV + 2; i++) begin
            int d;
            logic [31:0] w;
            @(negedge clk);
            d = ((cyc - 1) / SCAN_DIV) % 8;
            w = model_word();
            check("an", 32'(an), 32'(8'hFF ^ (8'd1 << d)));
            check("seg", 32'(seg), 32'(hex_seg(int'((w >> (4 * d)) & 32'hF))));
            check("dp", 32'(dp), (d == 0 && zero_m) ? 32'd0 : 32'd1);
        end
    endtask

    task automatic cpu_pulse();
        cpu_clk = 1'b1;
        pc_m = pc; alu_m = alures; zero_m = zero;
        wait_clk(3);
        cpu_clk = 1'b0;
        wait_clk(3);
    endtask

    task automatic press(input int len);
        page_btn = 1'b1;
        wait_clk(len);
        page_btn = 1'b0;
        wait_clk(10);
        if (len >= DEB) page_m = (page_m + 1) % 4;
        check("page", 32'(page), 32'(page_m));
    endtask

    initial begin
        reset = 1'b1;
        wait_clk(3);
        x_watch = 1'b1;
        check("rst_an", 32'(an), 32'hFF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_page", 32'(page), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("first_an", 32'(an), 32'hFE);
        check_frame();

        pc = 64'h0000_0001_1234_ABCD;
        cpu_pulse();
        check_frame();
        press(1);
        press(2);
        press(5);
        check_frame();

        zero = 1'b1; alures = 64'd0;
        cpu_pulse();
        pc = {$urandom, $urandom}; alures = {$urandom, $urandom}; zero = 1'b0;
        check_frame();
        press(3);
        check_frame();
        for (int i = 0; i < 5; i++) press(DEB + int'($urandom_range(0, 3)));

        for (int r = 0; r < 12; r++) begin
            pc = {$urandom, $urandom};
            alures = {$urandom, $urandom};
            zero = 1'($urandom);
            cpu_pulse();
            pc = {$urandom, $urandom};
            alures = {$urandom, $urandom};
            zero = 1'($urandom);
            press(int'($urandom_range(1, 6)));
            check_frame();
        end

        // cpu_clk rise captured exactly on a digit-wrap edge
        begin
            int guard = 0;
            while ((cyc % SCAN_DIV) != 1 && guard < 2 * SCAN_DIV) begin
                @(negedge clk);
                guard++;
            end
            check("wrap_align", 32'(cyc % SCAN_DIV), 32'd1);
            pc = {$urandom, $urandom}; alures = {$urandom, $urandom}; zero = 1'b1;
            cpu_pulse();
            check_frame();
        end

        // Reset in the middle of digit 5 while on page 2
        begin
            int guard = 0;
            while (page_m != 2 && guard < 4) begin
                press(DEB + 2);
                guard++;
            end
            check("page_two", 32'(page), 32'd2);
            guard = 0;
            while ((((cyc - 1) / SCAN_DIV) % 8) != 5 && guard < 16 * SCAN_DIV) begin
                @(negedge clk);
                guard++;
            end
            check("on_digit5", 32'(an), 32'hDF);
            reset = 1'b1;
            @(negedge clk);
            check("mid_rst_an", 32'(an), 32'hFF);
            check("mid_rst_seg", 32'(seg), 32'h7F);
            check("mid_rst_dp", 32'(dp), 32'd1);
            check("mid_rst_page", 32'(page), 32'd0);
            reset = 1'b0;
            pc_m = 64'd0; alu_m = 64'd0; zero_m = 1'b0; page_m = 0;
            check_frame();
        end

        x_watch = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
